// File: rtl/mem_bit_sequencer_if.sv
// Word-fetch port between the bit sequencer (master) and tag memory (slave).
// The master holds req, bank and addr stable until the slave pulses ack with rdata.
interface mem_bit_sequencer_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 8
);
    logic              req;
    logic [1:0]        bank;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [WORD_W-1:0] rdata;

    modport master (output req, bank, addr, input ack, rdata);
    modport slave  (input req, bank, addr, output ack, rdata);
endinterface

// File: rtl/mem_bit_sequencer.sv
// Serialises WORD_W-bit memory words MSB-first, one bit per i_bit_req, prefetching one word ahead.
// First bit is valid one cycle after the first ack; a word missing at its boundary flags underrun and stalls in PRIME.
module mem_bit_sequencer #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_abort,
    input  logic                i_start,
    input  logic [1:0]          i_bank,
    input  logic [ADDR_W-1:0]   i_ptr,
    input  logic [ADDR_W-1:0]   i_words,
    input  logic                i_bit_req,
    mem_bit_sequencer_if.master mem_if,
    output logic                o_membitsrc,
    output logic                o_memdatadone,
    output logic                o_ready,
    output logic                o_busy,
    output logic                o_underrun
);
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [ADDR_W:0]   ONE_W    = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_SHIFT, S_DONE} sh_state_t;
    typedef enum logic {F_IDLE, F_REQ} f_state_t;

    sh_state_t          r_state, w_state_nxt;
    f_state_t           r_fstate, w_fstate_nxt;
    logic [1:0]         r_bank;
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W-1:0]  r_words;
    logic [ADDR_W:0]    r_fetched;
    logic [ADDR_W:0]    r_consumed;
    logic [WORD_W-1:0]  r_shreg;
    logic [WORD_W-1:0]  r_nbuf;
    logic               r_nbuf_vld;
    logic [CNT_W-1:0]   r_bitcnt;
    logic               r_underrun;
    logic [1:0]         r_mem_bank;
    logic [ADDR_W-1:0]  r_mem_addr;

    logic w_ack, w_launch, w_shift, w_boundary, w_last_word, w_issue;

    always_comb begin
        w_ack       = mem_if.ack && (r_fstate == F_REQ);
        w_launch    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_shift     = (r_state == S_SHIFT) && i_bit_req;
        w_boundary  = w_shift && (r_bitcnt == LAST_BIT);
        w_last_word = (r_consumed + ONE_W) == {1'b0, r_words};
        // The shifter is the fetch target while priming; otherwise only an empty next-word buffer is.
        w_issue     = (r_fstate == F_IDLE) && (r_fetched < {1'b0, r_words}) &&
                      ((r_state == S_PRIME) || ((r_state == S_SHIFT) && !r_nbuf_vld));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_launch) w_state_nxt = (i_words == '0) ? S_DONE : S_PRIME;
            S_PRIME:        if (w_ack) w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_boundary) begin
                    if (w_last_word)              w_state_nxt = S_DONE;
                    else if (!r_nbuf_vld && !w_ack) w_state_nxt = S_PRIME;
                end
            end
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_fstate_nxt = r_fstate;
        case (r_fstate)
            F_IDLE:  if ((w_launch && (i_words != '0)) || w_issue) w_fstate_nxt = F_REQ;
            F_REQ:   if (w_ack) w_fstate_nxt = F_IDLE;
            default: w_fstate_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || i_abort) begin
            r_state  <= S_IDLE;
            r_fstate <= F_IDLE;
        end else begin
            r_state  <= w_state_nxt;
            r_fstate <= w_fstate_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_abort) begin
            r_bank     <= '0;
            r_ptr      <= '0;
            r_words    <= '0;
            r_fetched  <= '0;
            r_consumed <= '0;
            r_shreg    <= '0;
            r_nbuf     <= '0;
            r_nbuf_vld <= 1'b0;
            r_bitcnt   <= '0;
            r_underrun <= 1'b0;
            r_mem_bank <= '0;
            r_mem_addr <= '0;
        end else if (w_launch) begin
            r_bank     <= i_bank;
            r_ptr      <= i_ptr;
            r_words    <= i_words;
            r_fetched  <= '0;
            r_consumed <= '0;
            r_shreg    <= '0;
            r_nbuf_vld <= 1'b0;
            r_bitcnt   <= '0;
            r_underrun <= 1'b0;
            r_mem_bank <= i_bank;
            r_mem_addr <= i_ptr;
        end else begin
            if (w_issue) begin
                r_mem_bank <= r_bank;
                r_mem_addr <= r_ptr + r_fetched[ADDR_W-1:0];
            end
            if (w_ack) r_fetched <= r_fetched + ONE_W;

            if ((r_state == S_PRIME) && w_ack) begin
                r_shreg  <= mem_if.rdata;
                r_bitcnt <= '0;
            end else if (w_shift) begin
                r_bitcnt <= r_bitcnt + CNT_W'(1);
                if (w_boundary) begin
                    r_consumed <= r_consumed + ONE_W;
                    if (!w_last_word) begin
                        if (r_nbuf_vld) begin
                            r_shreg    <= r_nbuf;
                            r_nbuf_vld <= 1'b0;
                        end else if (w_ack) begin
                            r_shreg <= mem_if.rdata;
                        end else begin
                            r_underrun <= 1'b1;
                        end
                    end
                end else begin
                    r_shreg <= r_shreg << 1;
                end
            end

            // A word arriving mid-word parks in the buffer; at a boundary it was bypassed above.
            if ((r_state == S_SHIFT) && w_ack && !w_boundary) begin
                r_nbuf     <= mem_if.rdata;
                r_nbuf_vld <= 1'b1;
            end
        end
    end

    assign mem_if.req    = (r_fstate == F_REQ);
    assign mem_if.bank   = r_mem_bank;
    assign mem_if.addr   = r_mem_addr;
    assign o_membitsrc   = (r_state == S_SHIFT) && r_shreg[WORD_W-1];
    assign o_memdatadone = (r_state == S_DONE);
    assign o_ready       = (r_state == S_SHIFT);
    assign o_busy        = (r_state == S_PRIME) || (r_state == S_SHIFT);
    assign o_underrun    = r_underrun;
endmodule
